// File: rtl/sramlike_axi_bridge.sv
// Bridges the inst and data sram-like ports onto one AXI3 master; one transaction in flight, data has priority.
// Optional macro WRITE_RESP_WAIT_EN: write data_ok waits for the B response instead of the AW/W completion.
module sramlike_axi_bridge #(
   parameter logic [3:0] AXI_ID_I = 4'd0,
   parameter logic [3:0] AXI_ID_D = 4'd1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [7:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,
   output logic [3:0]  wid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic [3:0]  bid,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

`ifdef WRITE_RESP_WAIT_EN
   localparam logic WR_OK_ON_B = 1'b1;
`else
   localparam logic WR_OK_ON_B = 1'b0;
`endif

   typedef enum logic [2:0] {ST_IDLE, ST_AR, ST_R, ST_AW_W, ST_B} state_t;

   state_t      r_state;
   state_t      w_state_n;
   logic        r_sel;
   logic [1:0]  r_size;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_aw_done;
   logic        r_w_done;

   logic        w_grant;
   logic        w_grant_d;
   logic        w_grant_wr;
   logic        w_aw_fire;
   logic        w_w_fire;
   logic        w_rd_done;
   logic        w_wr_done;
   logic        w_done;
   logic [3:0]  w_id;
   logic        w_unused_ok;

   function automatic logic [3:0] f_wstrb(input logic [1:0] size, input logic [1:0] a);
      logic [3:0] s;
      case (size)
         2'd0:    s = 4'b0001 << a;
         2'd1:    s = a[1] ? 4'b1100 : 4'b0011;
         default: s = 4'b1111;
      endcase
      return s;
   endfunction

   // Every handshake output is gated by resetn so a reset abandons the transaction immediately.
   always_comb begin
      w_state_n    = r_state;
      w_grant      = 1'b0;
      w_grant_d    = 1'b0;
      w_grant_wr   = 1'b0;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      arvalid      = 1'b0;
      rready       = 1'b0;
      awvalid      = 1'b0;
      wvalid       = 1'b0;
      bready       = 1'b0;
      w_aw_fire    = 1'b0;
      w_w_fire     = 1'b0;
      w_rd_done    = 1'b0;
      w_wr_done    = 1'b0;
      if (resetn) begin
         case (r_state)
            ST_IDLE: begin
               if (data_req) begin
                  data_addr_ok = 1'b1;
                  w_grant      = 1'b1;
                  w_grant_d    = 1'b1;
                  w_grant_wr   = data_wr;
               end else if (inst_req) begin
                  inst_addr_ok = 1'b1;
                  w_grant      = 1'b1;
                  w_grant_wr   = inst_wr;
               end
               if (w_grant) begin
                  w_state_n = w_grant_wr ? ST_AW_W : ST_AR;
               end
            end
            ST_AR: begin
               arvalid = 1'b1;
               if (arready) begin
                  w_state_n = ST_R;
               end
            end
            ST_R: begin
               rready = 1'b1;
               if (rvalid && rlast) begin
                  w_rd_done = 1'b1;
                  w_state_n = ST_IDLE;
               end
            end
            ST_AW_W: begin
               awvalid   = !r_aw_done;
               wvalid    = !r_w_done;
               w_aw_fire = !r_aw_done && awready;
               w_w_fire  = !r_w_done && wready;
               if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
                  w_wr_done = !WR_OK_ON_B;
                  w_state_n = ST_B;
               end
            end
            ST_B: begin
               bready = 1'b1;
               if (bvalid) begin
                  w_wr_done = WR_OK_ON_B;
                  w_state_n = ST_IDLE;
               end
            end
            default: w_state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state   <= ST_IDLE;
         r_sel     <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         if (w_grant) begin
            r_sel     <= w_grant_d;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end else begin
            if (w_aw_fire) r_aw_done <= 1'b1;
            if (w_w_fire)  r_w_done  <= 1'b1;
         end
      end
   end

   // Request payload is captured only on a grant, so it stays stable while any valid is raised.
   always_ff @(posedge clk) begin
      if (w_grant) begin
         r_size  <= w_grant_d ? data_size  : inst_size;
         r_addr  <= w_grant_d ? data_addr  : inst_addr;
         r_wdata <= w_grant_d ? data_wdata : inst_wdata;
      end
   end

   assign w_id         = r_sel ? AXI_ID_D : AXI_ID_I;
   assign w_done       = w_rd_done | w_wr_done;
   assign inst_data_ok = w_done & ~r_sel;
   assign data_data_ok = w_done & r_sel;
   assign inst_rdata   = rdata;
   assign data_rdata   = rdata;

   assign arid    = w_id;
   assign araddr  = r_addr;
   assign arlen   = 8'd0;
   assign arsize  = {1'b0, r_size};
   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;

   assign awid    = w_id;
   assign awaddr  = r_addr;
   assign awlen   = 8'd0;
   assign awsize  = {1'b0, r_size};
   assign awburst = 2'b01;
   assign awlock  = 2'b00;
   assign awcache = 4'd0;
   assign awprot  = 3'd0;

   assign wid   = w_id;
   assign wdata = r_wdata;
   assign wstrb = f_wstrb(r_size, r_addr[1:0]);
   assign wlast = 1'b1;

   assign w_unused_ok = ^{rid, rresp, bid, bresp};

endmodule
